// File: rtl/irq_pkg.sv
// Shared constants and state encoding for the interrupt controller.
package irq_pkg;

    // Register map seen on the IO load/store bus
    localparam logic [1:0] IRQ_MASK  = 2'd0;
    localparam logic [1:0] IRQ_PEND  = 2'd1;
    localparam logic [1:0] IRQ_CAUSE = 2'd2;
    localparam logic [1:0] IRQ_TRIG  = 2'd3;

    localparam int CAUSE_W = 3;

    // Bit positions inside the CAUSE register
    localparam int CAUSE_SVC_BIT = 8;
    localparam int CAUSE_REQ_BIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_contr_if.sv
// Register bus and core exception handshake between the MIPS core and irq_contr.
interface irq_contr_if
    import irq_pkg::*;
#(
    parameter int N_SRC = 4
);
    logic                 reg_we;
    logic [1:0]           reg_addr;
    logic [31:0]          reg_wdata;
    logic [31:0]          reg_rdata;
    logic                 irq;
    logic [CAUSE_W-1:0]   irq_cause;
    logic                 irq_ack;
    logic                 eret;
    logic                 in_service;

    // Core / IO decoder side
    modport master (
        output reg_we, reg_addr, reg_wdata, irq_ack, eret,
        input  reg_rdata, irq, irq_cause, in_service
    );

    // Interrupt controller side
    modport slave (
        input  reg_we, reg_addr, reg_wdata, irq_ack, eret,
        output reg_rdata, irq, irq_cause, in_service
    );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending vector.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]   pend_i,
    output logic [CAUSE_W-1:0] idx_o,
    output logic               valid_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pend_i[i]) begin
                idx_o   = CAUSE_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_contr.sv
// Interrupt controller: pending latch, mask/trigger registers, priority
// selection and the request/acknowledge/return handshake with the core.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   ST_IDLE    | no request outstanding, waiting for a valid source
//   ST_REQ     | irq asserted, waiting for irq_ack (or withdrawal)
//   ST_SERVICE | handler running, waiting for eret; no nesting
module irq_contr
    import irq_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [N_SRC-1:0]  src_i,
    irq_contr_if.slave        bus
);

    irq_state_e          state_q;
    logic [N_SRC-1:0]    mask_q, mask_d;
    logic [N_SRC-1:0]    trig_q, trig_d;
    logic [N_SRC-1:0]    pend_q, pend_d;
    logic [N_SRC-1:0]    src_d_q;
    logic                irq_q;
    logic [CAUSE_W-1:0]  cause_q;
    logic                in_service_q;

    logic [N_SRC-1:0]    rise;
    logic [N_SRC-1:0]    w1c;
    logic [N_SRC-1:0]    ack_clr;
    logic [N_SRC-1:0]    cause_onehot;
    logic [CAUSE_W-1:0]  sel_idx;
    logic                sel_valid;
    logic                ack_take;
    logic [31:0]         rdata;
    logic                unused_wdata;

    assign unused_wdata = ^bus.reg_wdata;

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .pend_i  (pend_q & mask_q),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    assign ack_take = (state_q == ST_REQ) && bus.irq_ack;

    // Next values for MASK/TRIG/PENDING; level bits just mirror the input
    always_comb begin
        mask_d = mask_q;
        trig_d = trig_q;
        w1c    = '0;
        if (bus.reg_we) begin
            case (bus.reg_addr)
                IRQ_MASK: mask_d = bus.reg_wdata[N_SRC-1:0];
                IRQ_TRIG: trig_d = bus.reg_wdata[N_SRC-1:0];
                IRQ_PEND: w1c    = bus.reg_wdata[N_SRC-1:0];
                default:  ;
            endcase
        end

        for (int i = 0; i < N_SRC; i++) begin
            cause_onehot[i] = (cause_q == CAUSE_W'(i));
        end
        ack_clr = ack_take ? (cause_onehot & trig_q) : '0;

        rise   = src_i & ~src_d_q;
        // New edge beats any clear landing in the same cycle
        pend_d = (trig_q & ((pend_q & ~w1c & ~ack_clr) | rise))
               | (~trig_q & src_i);
    end

    // Configuration, pending and edge-detect registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mask_q  <= '0;
            trig_q  <= '1;
            pend_q  <= '0;
            src_d_q <= '0;
        end else begin
            mask_q  <= mask_d;
            trig_q  <= trig_d;
            pend_q  <= pend_d;
            src_d_q <= src_i;
        end
    end

    // Handshake FSM with registered irq / cause / in_service
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            irq_q        <= 1'b0;
            cause_q      <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid) begin
                        cause_q <= sel_idx;
                        irq_q   <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack wins over withdrawal and over a stray eret
                    if (bus.irq_ack) begin
                        irq_q        <= 1'b0;
                        in_service_q <= 1'b1;
                        state_q      <= ST_SERVICE;
                    end else if (!sel_valid) begin
                        irq_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eret) begin
                        in_service_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    irq_q        <= 1'b0;
                    in_service_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    // Combinational register read, unused bits zero
    always_comb begin
        rdata = '0;
        case (bus.reg_addr)
            IRQ_MASK:  rdata = 32'(mask_q);
            IRQ_PEND:  rdata = 32'(pend_q);
            IRQ_TRIG:  rdata = 32'(trig_q);
            IRQ_CAUSE: begin
                rdata[CAUSE_SVC_BIT] = in_service_q;
                rdata[CAUSE_REQ_BIT] = (state_q == ST_REQ);
                rdata[CAUSE_W-1:0]   = cause_q;
            end
            default:   rdata = '0;
        endcase
    end

    assign bus.reg_rdata  = rdata;
    assign bus.irq        = irq_q;
    assign bus.irq_cause  = cause_q;
    assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_irq_contr.sv
// Directed test of irq_contr with hand-computed expectations.
module tb_irq_contr;
    import irq_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] src;
    int           checks   = 0;
    int           failures = 0;

    irq_contr_if #(.N_SRC(N)) bus ();

    irq_contr #(.N_SRC(N)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .src_i   (src),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        bus.reg_we    = 1'b1;
        bus.reg_addr  = addr;
        bus.reg_wdata = data;
        tick();
        bus.reg_we    = 1'b0;
        bus.reg_wdata = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        bus.reg_addr = addr;
        #1;
        chk(tag, bus.reg_rdata, exp);
    endtask

    task automatic chk_out(input string tag, input logic irq, input logic [2:0] cause, input logic svc);
        chk({tag, "_irq"}, 32'(bus.irq), 32'(irq));
        chk({tag, "_cause"}, 32'(bus.irq_cause), 32'(cause));
        chk({tag, "_svc"}, 32'(bus.in_service), 32'(svc));
    endtask

    initial begin
        reset         = 1'b1;
        src           = 4'b0100;
        bus.reg_we    = 1'b0;
        bus.reg_addr  = IRQ_MASK;
        bus.reg_wdata = '0;
        bus.irq_ack   = 1'b0;
        bus.eret      = 1'b0;
        tick();
        tick();

        // Reset state
        chk_out("reset", 1'b0, 3'd0, 1'b0);
        rd_chk("reset_mask", IRQ_MASK, 32'h0);
        rd_chk("reset_trig", IRQ_TRIG, 32'hF);
        rd_chk("reset_pend", IRQ_PEND, 32'h0);

        // Source high at release: pending set, but MASK=0 means no request
        reset = 1'b0;
        tick();
        rd_chk("rel_pend", IRQ_PEND, 32'h4);
        tick();
        tick();
        chk("rel_noirq", 32'(bus.irq), 32'h0);
        src = 4'b0000;
        wr(IRQ_PEND, 32'h4);
        rd_chk("rel_w1c", IRQ_PEND, 32'h0);

        // Basic edge source
        wr(IRQ_MASK, 32'h1);
        src = 4'b0001;
        tick();
        rd_chk("edge_pend", IRQ_PEND, 32'h1);
        chk("edge_irq_n1", 32'(bus.irq), 32'h0);
        src = 4'b0000;
        tick();
        chk_out("edge_req", 1'b1, 3'd0, 1'b0);
        rd_chk("edge_cause_reg", IRQ_CAUSE, 32'h10);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk_out("edge_ack", 1'b0, 3'd0, 1'b1);
        rd_chk("edge_pend_clr", IRQ_PEND, 32'h0);
        rd_chk("edge_cause_svc", IRQ_CAUSE, 32'h100);
        tick();
        chk("edge_hold_svc", 32'(bus.in_service), 32'h1);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        chk_out("edge_eret", 1'b0, 3'd0, 1'b0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk_out("edge_stray_ack", 1'b0, 3'd0, 1'b0);

        // Priority: bits 1 and 2 together, 1 first
        wr(IRQ_MASK, 32'hF);
        src = 4'b0110;
        tick();
        src = 4'b0000;
        tick();
        chk_out("prio_req1", 1'b1, 3'd1, 1'b0);
        rd_chk("prio_pend", IRQ_PEND, 32'h6);
        bus.irq_ack = 1'b1;
        bus.eret    = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.eret    = 1'b0;
        chk_out("prio_ack_eret", 1'b0, 3'd1, 1'b1);
        rd_chk("prio_pend_ack", IRQ_PEND, 32'h4);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        chk_out("prio_idle", 1'b0, 3'd1, 1'b0);
        tick();
        chk_out("prio_req2", 1'b1, 3'd2, 1'b0);
        // Higher-priority arrival while in REQ does not replace the cause
        src = 4'b0001;
        tick();
        src = 4'b0000;
        tick();
        chk_out("prio_keep", 1'b1, 3'd2, 1'b0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        rd_chk("prio_pend_b0", IRQ_PEND, 32'h1);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        tick();
        chk_out("prio_req0", 1'b1, 3'd0, 1'b0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;

        // Withdraw in REQ by masking
        src = 4'b1000;
        tick();
        src = 4'b0000;
        tick();
        chk_out("wd_req", 1'b1, 3'd3, 1'b0);
        wr(IRQ_MASK, 32'h0);
        tick();
        chk_out("wd_drop", 1'b0, 3'd3, 1'b0);
        wr(IRQ_MASK, 32'hF);
        chk("wd_restore_n0", 32'(bus.irq), 32'h0);
        tick();
        chk_out("wd_rereq", 1'b1, 3'd3, 1'b0);

        // Same-cycle W1C and new edge on bit 3
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        src = 4'b1000;
        tick();
        src = 4'b0000;
        tick();
        rd_chk("sim_pend_pre", IRQ_PEND, 32'h8);
        src = 4'b1000;
        wr(IRQ_PEND, 32'h8);
        rd_chk("sim_set_wins", IRQ_PEND, 32'h8);
        src = 4'b0000;
        wr(IRQ_PEND, 32'h8);
        rd_chk("sim_w1c_only", IRQ_PEND, 32'h0);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        tick();
        chk_out("sim_idle", 1'b0, 3'd3, 1'b0);

        // Level mode
        wr(IRQ_TRIG, 32'h0);
        src = 4'b0010;
        tick();
        rd_chk("lvl_pend", IRQ_PEND, 32'h2);
        tick();
        chk_out("lvl_req", 1'b1, 3'd1, 1'b0);
        wr(IRQ_PEND, 32'h2);
        rd_chk("lvl_w1c_ign", IRQ_PEND, 32'h2);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        rd_chk("lvl_pend_ack", IRQ_PEND, 32'h2);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        chk_out("lvl_eret", 1'b0, 3'd1, 1'b0);
        tick();
        chk_out("lvl_rereq", 1'b1, 3'd1, 1'b0);
        src = 4'b0000;
        tick();
        rd_chk("lvl_pend_low", IRQ_PEND, 32'h0);
        tick();
        chk_out("lvl_withdraw", 1'b0, 3'd1, 1'b0);

        // Reset during SERVICE with a pending level source
        src = 4'b0010;
        tick();
        tick();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk_out("rst_pre_svc", 1'b0, 3'd1, 1'b1);
        reset = 1'b1;
        tick();
        chk_out("rst_mid", 1'b0, 3'd0, 1'b0);
        rd_chk("rst_mask", IRQ_MASK, 32'h0);
        rd_chk("rst_trig", IRQ_TRIG, 32'hF);
        rd_chk("rst_pend", IRQ_PEND, 32'h0);
        reset = 1'b0;
        tick();
        rd_chk("rst_rel_pend", IRQ_PEND, 32'h2);
        tick();
        tick();
        chk("rst_noirq", 32'(bus.irq), 32'h0);
        wr(IRQ_MASK, 32'h2);
        tick();
        chk_out("rst_mask_req", 1'b1, 3'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
